adc_packetizer_s2mm: RTL and testbench

//  Parametrised successor packetizer between an ADC AXI-Stream source and an AXI DMA S2MM channel.

---
 rtl/adc_packetizer_s2mm_pkg.sv | 25 ++
 rtl/adc_packetizer_s2mm_if.sv | 12 +
 rtl/axis_skid_buffer.sv | 66 ++++++
 rtl/adc_packetizer_s2mm.sv | 142 ++++++++++++++
 tb/tb_adc_packetizer_s2mm.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_packetizer_s2mm_pkg.sv
// Shared types and helpers for the ADC-to-S2MM packetizer.
package adc_packetizer_s2mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } pkt_state_t;

  localparam int unsigned HDR_MAX_W      = 128;
  localparam int unsigned HDR_HALF_MAX_W = HDR_MAX_W / 2;

  // Header word {cnt[half_w-1:0], len[half_w-1:0]}, right-aligned in HDR_MAX_W bits
  function automatic logic [HDR_MAX_W-1:0] make_header(
    input logic [HDR_HALF_MAX_W-1:0] cnt,
    input logic [HDR_HALF_MAX_W-1:0] len,
    input int unsigned               half_w
  );
    logic [HDR_MAX_W-1:0] mask;
    mask = (HDR_MAX_W'(1) << half_w) - HDR_MAX_W'(1);
    return ((HDR_MAX_W'(cnt) & mask) << half_w) | (HDR_MAX_W'(len) & mask);
  endfunction

endpackage

// File: rtl/adc_packetizer_s2mm_if.sv
// AXI-Stream bundle used on both sides of the packetizer.
interface adc_packetizer_s2mm_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry registered ready/valid buffer: full throughput, one cycle latency.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             in_ready_d_c,
  output logic             nonempty_d_c
);

  logic [WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic             push;

  assign in_ready = ~skid_valid_q;
  assign push     = in_valid && !skid_valid_q;

  // Output slot refills from the skid entry first, otherwise straight from the input
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign in_ready_d_c = ~skid_valid_d;
  assign nonempty_d_c = out_valid_d;

endmodule

// File: rtl/adc_packetizer_s2mm.sv
// Cuts an ADC sample stream into cfg_len-beat packets for an AXI DMA S2MM channel.
// Optional PACKETIZER_HEADER_EN prepends one {pkt_started, len} header beat per packet.
module adc_packetizer_s2mm
  import adc_packetizer_s2mm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  adc_packetizer_s2mm_if.slave  s_axis,
  adc_packetizer_s2mm_if.master m_axis,
  input  logic                  cfg_enable,
  input  logic                  cfg_oneshot,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic [CNT_WIDTH-1:0]  pkt_started,
  output logic [CNT_WIDTH-1:0]  pkt_done,
  output logic                  busy
);

  localparam int unsigned BUF_W  = DATA_WIDTH + 1;
  localparam int unsigned HALF_W = DATA_WIDTH / 2;

  pkt_state_t           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d, beat_q, beat_d;
  logic [CNT_WIDTH-1:0] started_q, started_d, done_q;
  logic                 busy_q, tready_q;
  logic                 start_ok, s_acc, last_beat, hdr_push;
  logic [BUF_W-1:0]     buf_in_data, buf_out_data;
  logic                 buf_in_valid, buf_in_ready, buf_out_valid;
  logic                 buf_ready_d, buf_nonempty_d;
  logic [DATA_WIDTH-1:0] hdr_word;
  logic                 unused_s_tlast;

`ifdef PACKETIZER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
  assign hdr_word = DATA_WIDTH'(make_header(HDR_HALF_MAX_W'(started_q),
                                            HDR_HALF_MAX_W'(len_q), HALF_W));
`else
  localparam bit HDR_EN = 1'b0;
  assign hdr_word = '0;
`endif

  assign unused_s_tlast = s_axis.tlast;
  assign start_ok  = cfg_enable && (cfg_len != '0);
  assign s_acc     = s_axis.tvalid && tready_q;
  assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));
  assign hdr_push  = (state_q == HDR) && buf_in_ready;

  // tready_q already implies buffer space, so an accepted input beat is always pushed
  assign buf_in_valid = (state_q == HDR) || s_acc;
  assign buf_in_data  = (state_q == HDR) ? {1'b0, hdr_word} : {last_beat, s_axis.tdata};

  // Packet sequencing; configuration is only sampled at packet boundaries
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    started_d = started_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d     = cfg_len;
          beat_d    = '0;
          started_d = started_q + CNT_WIDTH'(1);
          if (HDR_EN) state_d = HDR;
          else        state_d = RUN;
        end
      end
      HDR: begin
        if (hdr_push) state_d = RUN;
      end
      RUN: begin
        if (s_acc) begin
          if (last_beat) begin
            beat_d = '0;
            if (cfg_oneshot) begin
              state_d = DONE;
            end else if (start_ok) begin
              len_d     = cfg_len;
              started_d = started_q + CNT_WIDTH'(1);
              if (HDR_EN) state_d = HDR;
              else        state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (!cfg_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      started_q <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      started_q <= started_d;
      tready_q  <= (state_d == RUN) && buf_ready_d;
      busy_q    <= (state_d != IDLE) || buf_nonempty_d;
      if (buf_out_valid && m_axis.tready && buf_out_data[DATA_WIDTH])
        done_q <= done_q + CNT_WIDTH'(1);
    end
  end

  axis_skid_buffer #(.WIDTH(BUF_W)) u_skid (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .in_data      (buf_in_data),
    .in_valid     (buf_in_valid),
    .in_ready     (buf_in_ready),
    .out_data     (buf_out_data),
    .out_valid    (buf_out_valid),
    .out_ready    (m_axis.tready),
    .in_ready_d_c (buf_ready_d),
    .nonempty_d_c (buf_nonempty_d)
  );

  assign s_axis.tready = tready_q;
  assign m_axis.tdata  = buf_out_data[DATA_WIDTH-1:0];
  assign m_axis.tlast  = buf_out_data[DATA_WIDTH];
  assign m_axis.tvalid = buf_out_valid;
  assign pkt_started   = started_q;
  assign pkt_done      = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_adc_packetizer_s2mm.sv
// Directed bench for adc_packetizer_s2mm; define PACKETIZER_HEADER_EN to exercise the header build.
module tb_adc_packetizer_s2mm;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 32;
  localparam int unsigned CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          cfg_enable = 1'b0;
  logic          cfg_oneshot = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [CW-1:0] pkt_started, pkt_done;
  logic          busy;

  adc_packetizer_s2mm_if #(.DATA_WIDTH(DW)) s_if ();
  adc_packetizer_s2mm_if #(.DATA_WIDTH(DW)) m_if ();

  adc_packetizer_s2mm #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .cfg_enable  (cfg_enable),
    .cfg_oneshot (cfg_oneshot),
    .cfg_len     (cfg_len),
    .pkt_started (pkt_started),
    .pkt_done    (pkt_done),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  int          total = 0;
  int          bad = 0;
  logic [DW-1:0] src_data = 32'h0000_1000;
  bit          src_on = 0, src_rand = 0, rdy_rand = 0, s_acc_flag = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_d[$];
  bit          out_l[$];
  int          in_cnt = 0;
  int          stall_viol = 0;
  bit          prev_stall = 0;
  logic [DW-1:0] prev_d = '0;
  bit          prev_l = 0;

  // Negedge monitor: handshakes seen here complete on the following posedge
  always @(negedge aclk) begin
    s_acc_flag = s_if.tvalid && s_if.tready;
    if (aresetn) begin
      if (s_acc_flag) begin
        in_q.push_back(s_if.tdata);
        in_cnt++;
      end
      if (m_if.tvalid && m_if.tready) begin
        out_d.push_back(m_if.tdata);
        out_l.push_back(m_if.tlast);
      end
      if (prev_stall && (!m_if.tvalid || m_if.tdata !== prev_d || m_if.tlast !== prev_l))
        stall_viol++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_d     = m_if.tdata;
      prev_l     = m_if.tlast;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
    if (s_acc_flag) src_data = src_data + 1;
    s_if.tvalid = src_rand ? 1'($urandom_range(0, 1)) : src_on;
    s_if.tdata  = src_data;
    s_if.tlast  = 1'b0;
    m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic clear_sb();
    in_q.delete();
    out_d.delete();
    out_l.delete();
    in_cnt     = 0;
    stall_viol = 0;
  endtask

  task automatic do_reset();
    cfg_enable = 0; cfg_oneshot = 0; cfg_len = '0;
    src_on = 0; src_rand = 0; rdy_rand = 0;
    aresetn = 0;
    step(); step();
    aresetn = 1;
    step();
    clear_sb();
  endtask

  task automatic drain(input int bound, output bit timed_out);
    for (int k = 0; k < bound && busy; k++) step();
    timed_out = busy;
  endtask

  task automatic test_reset();
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0; m_if.tready = 1;
    #1 aresetn = 0;
    repeat (3) step();
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", m_if.tvalid); end
    total++; if (m_if.tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b want 0", m_if.tlast); end
    total++; if (m_if.tdata !== '0) begin bad++; $display("FAIL rst_tdata: got %h want 0", m_if.tdata); end
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL rst_tready: got %b want 0", s_if.tready); end
    total++; if (pkt_started !== '0) begin bad++; $display("FAIL rst_started: got %0d want 0", pkt_started); end
    total++; if (pkt_done !== '0) begin bad++; $display("FAIL rst_done: got %0d want 0", pkt_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    aresetn = 1;
    // cfg_len == 0 keeps the block disabled even with enable high
    cfg_len = '0; cfg_enable = 1; src_on = 1;
    repeat (4) step();
    total++; if (pkt_started !== '0) begin bad++; $display("FAIL len0_started: got %0d want 0", pkt_started); end
    total++; if (busy !== 1'b0 || s_if.tready !== 1'b0) begin bad++; $display("FAIL len0_idle: got busy=%b tready=%b want 0/0", busy, s_if.tready); end
  endtask

  task automatic test_continuous();
    bit to;
    int base, n;
    do_reset();
    cfg_len = 10; src_on = 1;
    step();
    cfg_enable = 1;
    step();
    total++; if (pkt_started !== 32'd1) begin bad++; $display("FAIL cont_started1: got %0d want 1", pkt_started); end
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL cont_tready: got %b want 1", s_if.tready); end
    base = in_cnt;
    repeat (35) step();
    total++; if (in_cnt - base != 35) begin bad++; $display("FAIL cont_nobubble: got %0d beats want 35", in_cnt - base); end
    cfg_enable = 0;
    drain(100, to);
    n = out_d.size();
    total++; if (to) begin bad++; $display("FAIL cont_drain: got busy=1 want 0"); end
    total++; if (n != 40 || in_q.size() != 40) begin bad++; $display("FAIL cont_count: got out=%0d in=%0d want 40", n, in_q.size()); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (out_d[i] !== in_q[i] || out_l[i] !== (i % 10 == 9)) begin
        bad++; $display("FAIL cont_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], in_q[i], (i % 10 == 9));
      end
    end
    total++; if (pkt_done !== 32'd4) begin bad++; $display("FAIL cont_done: got %0d want 4", pkt_done); end
    total++; if (pkt_started !== 32'd4) begin bad++; $display("FAIL cont_started: got %0d want 4", pkt_started); end
  endtask

  task automatic test_oneshot();
    do_reset();
    cfg_len = 4; cfg_oneshot = 1; src_on = 1; cfg_enable = 1;
    repeat (12) step();
    total++; if (out_d.size() != 4 || in_cnt != 4) begin bad++; $display("FAIL os_count: got out=%0d in=%0d want 4", out_d.size(), in_cnt); end
    total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL os_tready: got %b want 0", s_if.tready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL os_busy_done: got %b want 1", busy); end
    total++; if (pkt_done !== 32'd1) begin bad++; $display("FAIL os_done1: got %0d want 1", pkt_done); end
    cfg_enable = 0;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL os_idle: got busy=%b want 0", busy); end
    cfg_enable = 1;
    repeat (12) step();
    total++; if (pkt_started !== 32'd2) begin bad++; $display("FAIL os_started2: got %0d want 2", pkt_started); end
    total++; if (pkt_done !== 32'd2 || out_d.size() != 8) begin bad++; $display("FAIL os_second: got done=%0d out=%0d want 2/8", pkt_done, out_d.size()); end
    for (int i = 0; i < out_d.size(); i++) begin
      total++;
      if (out_d[i] !== in_q[i] || out_l[i] !== (i % 4 == 3)) begin
        bad++; $display("FAIL os_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], in_q[i], (i % 4 == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int n, lasts;
    do_reset();
    cfg_len = 8; src_rand = 1; rdy_rand = 1; cfg_enable = 1;
    repeat (200) step();
    cfg_enable = 0;
    drain(400, to);
    src_rand = 0; rdy_rand = 0;
    n = out_d.size();
    lasts = 0;
    total++; if (to) begin bad++; $display("FAIL bp_drain: got busy=1 want 0"); end
    total++; if (n != in_q.size() || n % 8 != 0 || n == 0) begin bad++; $display("FAIL bp_count: got out=%0d in=%0d want equal nonzero multiple of 8", n, in_q.size()); end
    for (int i = 0; i < n; i++) begin
      if (out_l[i]) lasts++;
      total++;
      if (out_d[i] !== in_q[i] || out_l[i] !== (i % 8 == 7)) begin
        bad++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], in_q[i], (i % 8 == 7));
      end
    end
    total++; if (pkt_done !== CW'(lasts)) begin bad++; $display("FAIL bp_done: got %0d want %0d", pkt_done, lasts); end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_viol); end
  endtask

  task automatic test_len_change();
    bit to;
    do_reset();
    cfg_len = 8; src_on = 1; cfg_enable = 1;
    for (int k = 0; k < 50 && in_cnt < 2; k++) step();
    cfg_len = 3;
    for (int k = 0; k < 50 && in_cnt < 9; k++) step();
    total++; if (in_cnt != 9) begin bad++; $display("FAIL lc_wait: got %0d beats want 9", in_cnt); end
    cfg_enable = 0;
    drain(100, to);
    total++; if (to || out_d.size() != 11) begin bad++; $display("FAIL lc_count: got out=%0d busy=%b want 11/0", out_d.size(), busy); end
    for (int i = 0; i < out_d.size(); i++) begin
      total++;
      if (out_d[i] !== in_q[i] || out_l[i] !== (i == 7 || i == 10)) begin
        bad++; $display("FAIL lc_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], in_q[i], (i == 7 || i == 10));
      end
    end
    total++; if (pkt_done !== 32'd2 || pkt_started !== 32'd2) begin bad++; $display("FAIL lc_counters: got done=%0d started=%0d want 2/2", pkt_done, pkt_started); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    do_reset();
    cfg_len = 6; src_on = 1; cfg_enable = 1;
    for (int k = 0; k < 50 && in_cnt < 3; k++) step();
    aresetn = 0;
    #2;
    total++; if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== '0) begin bad++; $display("FAIL rm_mout: got v=%b l=%b d=%h want 0", m_if.tvalid, m_if.tlast, m_if.tdata); end
    total++; if (s_if.tready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_ctl: got tready=%b busy=%b want 0/0", s_if.tready, busy); end
    total++; if (pkt_started !== '0 || pkt_done !== '0) begin bad++; $display("FAIL rm_cnt: got started=%0d done=%0d want 0/0", pkt_started, pkt_done); end
    step(); step();
    clear_sb();
    aresetn = 1;
    step();
    total++; if (pkt_started !== 32'd1) begin bad++; $display("FAIL rm_restart: got %0d want 1", pkt_started); end
    repeat (20) step();
    cfg_enable = 0;
    drain(100, to);
    n = out_d.size();
    total++; if (to || n != in_q.size() || n % 6 != 0 || n == 0) begin bad++; $display("FAIL rm_count: got out=%0d in=%0d want equal nonzero multiple of 6", n, in_q.size()); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (out_d[i] !== in_q[i] || out_l[i] !== (i % 6 == 5)) begin
        bad++; $display("FAIL rm_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], in_q[i], (i % 6 == 5));
      end
    end
    total++; if (pkt_done !== CW'(n / 6)) begin bad++; $display("FAIL rm_done: got %0d want %0d", pkt_done, n / 6); end
  endtask

  task automatic test_header();
    bit to;
    int n, p, j;
    logic [DW-1:0] exp_d;
    bit exp_l;
    do_reset();
    cfg_len = 5; src_on = 1; cfg_enable = 1;
    for (int k = 0; k < 80 && out_d.size() < 12; k++) step();
    cfg_enable = 0;
    drain(100, to);
    n = out_d.size();
    total++; if (to || n % 6 != 0 || n < 12 || in_q.size() != (n / 6) * 5) begin bad++; $display("FAIL hdr_count: got out=%0d in=%0d want 6k/5k, k>=2", n, in_q.size()); end
    for (int i = 0; i < n; i++) begin
      p = i / 6;
      j = i % 6;
      if (j == 0) exp_d = {16'(p + 1), 16'd5};
      else        exp_d = in_q[p * 5 + j - 1];
      exp_l = (j == 5);
      total++;
      if (out_d[i] !== exp_d || out_l[i] !== exp_l) begin
        bad++; $display("FAIL hdr_beat%0d: got %h/%b want %h/%b", i, out_d[i], out_l[i], exp_d, exp_l);
      end
    end
    total++; if (pkt_done !== CW'(n / 6) || pkt_started !== CW'(n / 6)) begin bad++; $display("FAIL hdr_counters: got done=%0d started=%0d want %0d", pkt_done, pkt_started, n / 6); end
  endtask

  initial begin
    test_reset();
`ifdef PACKETIZER_HEADER_EN
    test_header();
`else
    test_continuous();
    test_oneshot();
    test_backpressure();
    test_len_change();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
